// File: rtl/imem_loader_if.sv
// Bundle of byte-stream handshake, instruction-memory write port and status
// signals for imem_loader. The slave modport is the loader's view.
interface imem_loader_if;
    logic        start;
    logic [15:0] base_addr;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] loaded_count;

    modport master (
        output start, base_addr, byte_valid, byte_data,
        input  byte_ready, mem_addr, mem_data, mem_wren, cpu_hold,
               busy, done, error, loaded_count
    );

    modport slave (
        input  start, base_addr, byte_valid, byte_data,
        output byte_ready, mem_addr, mem_data, mem_wren, cpu_hold,
               busy, done, error, loaded_count
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte image into instruction memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte (8-bit sum of all bytes == 0).
module imem_loader (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus_io
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CNT_HI = 4'd1,
        S_CNT_LO = 4'd2,
        S_DAT_HI = 4'd3,
        S_DAT_LO = 4'd4,
        S_WRITE  = 4'd5,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 4'd6,
`endif
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_S = S_CHK;
`else
    localparam state_e END_S = S_DONE;
`endif

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] loaded_q, loaded_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ready_q, wren_q, hold_q, busy_q, done_q;
    logic        accept_s;
    logic [15:0] idx_inc_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        error_q;
`endif

    function automatic logic takes_byte(input state_e s);
        case (s)
            S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                                  return 1'b1;
`endif
            default:                                return 1'b0;
        endcase
    endfunction

    // Next-state and datapath update; a byte moves only when valid meets a ready state
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        idx_d     = idx_q;
        loaded_d  = loaded_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        data_d    = data_q;
        accept_s  = bus_io.byte_valid & ready_q;
        idx_inc_s = idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        if (accept_s) begin
            sum_d = sum_q + bus_io.byte_data;
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus_io.start) begin
                    state_d  = S_CNT_HI;
                    base_d   = bus_io.base_addr;
                    idx_d    = 16'd0;
                    loaded_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_CNT_HI: begin
                if (accept_s) begin
                    count_d[15:8] = bus_io.byte_data;
                    state_d       = S_CNT_LO;
                end else begin
                    state_d = state_q;
                end
            end
            S_CNT_LO: begin
                if (accept_s) begin
                    count_d[7:0] = bus_io.byte_data;
                    if ({count_q[15:8], bus_io.byte_data} == 16'h0000) begin
                        state_d = END_S;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DAT_HI: begin
                if (accept_s) begin
                    hi_d    = bus_io.byte_data;
                    state_d = S_DAT_LO;
                end else begin
                    state_d = state_q;
                end
            end
            S_DAT_LO: begin
                if (accept_s) begin
                    data_d  = {hi_q, bus_io.byte_data};
                    addr_d  = base_q + idx_q;
                    state_d = S_WRITE;
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                idx_d    = idx_inc_s;
                loaded_d = loaded_q + 16'd1;
                if (idx_inc_s == count_q) begin
                    state_d = END_S;
                end else begin
                    state_d = S_DAT_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_s) begin
                    if (sum_d == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= 16'd0;
            count_q  <= 16'd0;
            idx_q    <= 16'd0;
            loaded_q <= 16'd0;
            hi_q     <= 8'd0;
            addr_q   <= 16'd0;
            data_q   <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            loaded_q <= loaded_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Status flags registered from the next state, so each tracks state_q exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            wren_q  <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            error_q <= 1'b0;
`endif
        end else begin
            ready_q <= takes_byte(state_d);
            wren_q  <= (state_d == S_WRITE);
            hold_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
            done_q  <= (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
            error_q <= (state_d == S_ERROR);
`endif
        end
    end

    assign bus_io.byte_ready   = ready_q;
    assign bus_io.mem_addr     = addr_q;
    assign bus_io.mem_data     = data_q;
    assign bus_io.mem_wren     = wren_q;
    assign bus_io.cpu_hold     = hold_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
    assign bus_io.loaded_count = loaded_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus_io.error        = error_q;
`else
    assign bus_io.error        = 1'b0;
`endif

endmodule
